// File: rtl/operand_fetch.sv
// operand_fetch: resolves RK(B)/RK(C) and reads each TValue (value word, then tag word)
// over a shared Avalon master. Ports: clk/rst, start/base/k/fld_b/fld_c/need_b/need_c in; busy/done/data_*/type_* out; mem_* Avalon read port.
module operand_fetch #(
  parameter int TV_SHIFT   = 3,
  parameter int TAG_OFFSET = 4,
  parameter int TTAG_SIZE  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          base,
  input  logic [31:0]          k,
  input  logic [8:0]           fld_b,
  input  logic [8:0]           fld_c,
  input  logic                 need_b,
  input  logic                 need_c,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          data_b,
  output logic [31:0]          data_c,
  output logic [TTAG_SIZE-1:0] type_b,
  output logic [TTAG_SIZE-1:0] type_c,
  output logic [31:0]          mem_address,
  output logic                 mem_read,
  input  logic [31:0]          mem_readdata,
  input  logic                 mem_waitrequest
);

  typedef enum logic [2:0] {
    IDLE, B_VAL, B_TAG, C_VAL, C_TAG, DONE
  } state_t;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] k;
    logic [8:0]  fb;
    logic [8:0]  fc;
    logic        nb;
    logic        nc;
  } req_t;

  state_t state, state_n;
  req_t   rq;

  logic [31:0] ea_b, ea_c;
  logic        ack;

  function automatic logic [31:0] ea(
    input logic [31:0] b,
    input logic [31:0] kk,
    input logic [8:0]  f
  );
    logic [31:0] off;
    off = {24'd0, f[7:0]} << TV_SHIFT;
    return (f[8] ? kk : b) + off;
  endfunction

  // Bit 6 (collectable) is dropped; only the variant/type bits matter.
  function automatic logic [TTAG_SIZE-1:0] map_tag(
    input logic [5:0] t
  );
    logic [TTAG_SIZE-1:0] r;
    unique case (1'b1)
      (t == 6'h00): r = TTAG_SIZE'(0);
      (t == 6'h13): r = TTAG_SIZE'(1);
      (t == 6'h03): r = TTAG_SIZE'(2);
      (t == 6'h04),
      (t == 6'h14): r = TTAG_SIZE'(3);
      (t == 6'h05): r = TTAG_SIZE'(4);
      (t == 6'h06),
      (t == 6'h16),
      (t == 6'h26): r = TTAG_SIZE'(5);
      default:      r = TTAG_SIZE'(6);
    endcase
    return r;
  endfunction

  assign ea_b = ea(rq.base, rq.k, rq.fb);
  assign ea_c = ea(rq.base, rq.k, rq.fc);
  assign ack  = ~mem_waitrequest;

  always_comb begin
    state_n     = state;
    mem_read    = 1'b0;
    mem_address = 32'd0;
    busy        = (state != IDLE);
    done        = (state == DONE);
    unique case (state)
      IDLE: begin
        if (start) begin
          if (need_b)      state_n = B_VAL;
          else if (need_c) state_n = C_VAL;
          else             state_n = DONE;
        end
      end
      B_VAL: begin
        mem_read    = 1'b1;
        mem_address = ea_b;
        if (ack) state_n = B_TAG;
      end
      B_TAG: begin
        mem_read    = 1'b1;
        mem_address = ea_b + 32'(TAG_OFFSET);
        if (ack) state_n = rq.nc ? C_VAL : DONE;
      end
      C_VAL: begin
        mem_read    = 1'b1;
        mem_address = ea_c;
        if (ack) state_n = C_TAG;
      end
      C_TAG: begin
        mem_read    = 1'b1;
        mem_address = ea_c + 32'(TAG_OFFSET);
        if (ack) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rq     <= '0;
      data_b <= 32'd0;
      data_c <= 32'd0;
      type_b <= '0;
      type_c <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (start) begin
            rq.base <= base;
            rq.k    <= k;
            rq.fb   <= fld_b;
            rq.fc   <= fld_c;
            rq.nb   <= need_b;
            rq.nc   <= need_c;
            if (!need_b) begin
              data_b <= 32'd0;
              type_b <= '0;
            end
            if (!need_c) begin
              data_c <= 32'd0;
              type_c <= '0;
            end
          end
        end
        B_VAL: if (ack) data_b <= mem_readdata;
        B_TAG: if (ack) type_b <= map_tag(mem_readdata[5:0]);
        C_VAL: if (ack) data_c <= mem_readdata;
        C_TAG: if (ack) type_c <= map_tag(mem_readdata[5:0]);
        default: ;
      endcase
    end
  end

endmodule
